// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store sequencer between the core memory stage and a
//               word-wide data memory with req/gnt/rvalid handshake.
//               Produces byte enables, lane-aligned store data and extended
//               load data. Also detects misaligned accesses and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    input  logic [ADDR_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Stall_o,
    output logic                  Done_o,
    output logic                  Misalign_o,
    output logic                  BusErr_o,
    output logic                  MemReq_o,
    output logic                  MemWe_o,
    output logic [ADDR_WIDTH-1:0] MemAddr_o,
    output logic [3:0]            MemBe_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    input  logic                  MemGnt_i,
    input  logic                  MemRValid_i,
    input  logic [DATA_WIDTH-1:0] MemRData_i
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [1:0]              r_type;
    logic                    r_sign;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_we;
    logic                    r_misalign;
    logic                    r_buserr;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_req;
    logic                    w_misalign_in;
    logic                    w_timeout;
    logic                    w_in_req;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;

    assign w_req     = MemRead_i | MemWrite_i;
    assign w_timeout = (r_cnt == c_TMO_LAST);
    assign w_in_req  = (r_state == ST_REQ);

    // Alignment check on the incoming request (byte accesses never misalign)
    always_comb begin
        w_misalign_in = 1'b0;
        case (MemType_i)
            2'b01:   w_misalign_in = 1'b0;
            2'b10:   w_misalign_in = Addr_i[0];
            default: w_misalign_in = |Addr_i[1:0];
        endcase
    end

    // Byte enables and lane-replicated store data from the latched request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_type)
            2'b01: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b10: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Lane extraction and extension of returning read data (sign=1 zero-extends)
    always_comb begin
        w_byte = MemRData_i[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? MemRData_i[31:16] : MemRData_i[15:0];
        w_load = MemRData_i;
        case (r_type)
            2'b01:   w_load = r_sign ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b10:   w_load = r_sign ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = MemRData_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a handshake event on the timeout cycle wins
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = w_misalign_in ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (MemGnt_i) begin
                    w_next = r_we ? ST_DONE : ST_WAIT;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (MemRValid_i || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture, status flags, timeout counter and load result register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr     <= '0;
            r_type     <= 2'b00;
            r_sign     <= 1'b0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr     <= Addr_i;
                        r_type     <= MemType_i;
                        r_sign     <= MemSign_i;
                        r_wdata    <= WriteData_i;
                        r_we       <= MemWrite_i;
                        r_misalign <= w_misalign_in;
                        r_buserr   <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                ST_REQ: begin
                    // Saturating so a late grant still leaves WAIT bounded
                    if (!w_timeout) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (!MemGnt_i && w_timeout) begin
                        r_buserr <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!w_timeout) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (MemRValid_i) begin
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_buserr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Stall_o    = ((r_state == ST_IDLE) && w_req) || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign Done_o     = (r_state == ST_DONE);
    assign Misalign_o = Done_o & r_misalign;
    assign BusErr_o   = Done_o & r_buserr;
    assign ReadData_o = r_rdata;

    assign MemReq_o   = w_in_req;
    assign MemWe_o    = w_in_req & r_we;
    assign MemAddr_o  = w_in_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign MemBe_o    = w_in_req ? w_be : 4'b0000;
    assign MemWData_o = w_in_req ? w_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed, table-driven self-checking bench for lsu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        MemRead_i, MemWrite_i, MemSign_i;
    logic [1:0]  MemType_i;
    logic [31:0] Addr_i, WriteData_i;
    logic [31:0] ReadData_o;
    logic        Stall_o, Done_o, Misalign_o, BusErr_o;
    logic        MemReq_o, MemWe_o;
    logic [31:0] MemAddr_o;
    logic [3:0]  MemBe_o;
    logic [31:0] MemWData_o;
    logic        MemGnt_i, MemRValid_i;
    logic [31:0] MemRData_i;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(64)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .MemType_i   (MemType_i),
        .MemSign_i   (MemSign_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .ReadData_o  (ReadData_o),
        .Stall_o     (Stall_o),
        .Done_o      (Done_o),
        .Misalign_o  (Misalign_o),
        .BusErr_o    (BusErr_o),
        .MemReq_o    (MemReq_o),
        .MemWe_o     (MemWe_o),
        .MemAddr_o   (MemAddr_o),
        .MemBe_o     (MemBe_o),
        .MemWData_o  (MemWData_o),
        .MemGnt_i    (MemGnt_i),
        .MemRValid_i (MemRValid_i),
        .MemRData_i  (MemRData_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  typ;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gdly;
        int          rdly;
        bit          mis;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access; entered and left just after a rising edge in IDLE
    task automatic run_vec(input int idx, input vec_t v);
        MemRead_i   = v.rd;
        MemWrite_i  = v.wr;
        MemType_i   = v.typ;
        MemSign_i   = v.sgn;
        Addr_i      = v.addr;
        WriteData_i = v.wdata;
        @(negedge clk_i);
        chk($sformatf("v%0d_idle_stall", idx), {31'd0, Stall_o}, 32'd1);
        chk($sformatf("v%0d_idle_req", idx), {31'd0, MemReq_o}, 32'd0);
        tick();
        if (v.mis) begin
            @(negedge clk_i);
            chk($sformatf("v%0d_mis_done", idx), {31'd0, Done_o}, 32'd1);
            chk($sformatf("v%0d_mis_flag", idx), {31'd0, Misalign_o}, 32'd1);
            chk($sformatf("v%0d_mis_req", idx), {31'd0, MemReq_o}, 32'd0);
            chk($sformatf("v%0d_mis_stall", idx), {31'd0, Stall_o}, 32'd0);
            chk($sformatf("v%0d_mis_rd", idx), ReadData_o, v.exp_rd);
        end else begin
            for (int k = 0; k <= v.gdly; k++) begin
                @(negedge clk_i);
                chk($sformatf("v%0d_req_%0d", idx, k), {31'd0, MemReq_o}, 32'd1);
                chk($sformatf("v%0d_addr_%0d", idx, k), MemAddr_o, v.maddr);
                chk($sformatf("v%0d_be_%0d", idx, k), {28'd0, MemBe_o}, {28'd0, v.be});
                chk($sformatf("v%0d_we_%0d", idx, k), {31'd0, MemWe_o}, {31'd0, v.wr});
                if (v.wr)
                    chk($sformatf("v%0d_wdata_%0d", idx, k), MemWData_o, v.mwdata);
                if (k == v.gdly) MemGnt_i = 1'b1;
                tick();
                MemGnt_i = 1'b0;
            end
            if (!v.wr) begin
                for (int k = 0; k <= v.rdly; k++) begin
                    @(negedge clk_i);
                    chk($sformatf("v%0d_wait_req_%0d", idx, k), {31'd0, MemReq_o}, 32'd0);
                    chk($sformatf("v%0d_wait_stall_%0d", idx, k), {31'd0, Stall_o}, 32'd1);
                    if (k == v.rdly) begin
                        MemRValid_i = 1'b1;
                        MemRData_i  = v.rdata;
                    end
                    tick();
                    MemRValid_i = 1'b0;
                    MemRData_i  = 32'h0BAD_0BAD;
                end
            end
            @(negedge clk_i);
            chk($sformatf("v%0d_done", idx), {31'd0, Done_o}, 32'd1);
            chk($sformatf("v%0d_done_mis", idx), {31'd0, Misalign_o}, 32'd0);
            chk($sformatf("v%0d_done_berr", idx), {31'd0, BusErr_o}, 32'd0);
            chk($sformatf("v%0d_done_stall", idx), {31'd0, Stall_o}, 32'd0);
            chk($sformatf("v%0d_done_rd", idx), ReadData_o, v.exp_rd);
        end
        tick();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        @(negedge clk_i);
        chk($sformatf("v%0d_post_done", idx), {31'd0, Done_o}, 32'd0);
        chk($sformatf("v%0d_post_stall", idx), {31'd0, Stall_o}, 32'd0);
        tick();
    endtask

    task automatic start_load(input logic [31:0] a);
        MemRead_i = 1'b1;
        MemWrite_i = 1'b0;
        MemType_i = 2'b00;
        MemSign_i = 1'b0;
        Addr_i    = a;
        tick();
    endtask

    task automatic finish_idle(input string name);
        tick();
        MemRead_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_idle_done"}, {31'd0, Done_o}, 32'd0);
        chk({name, "_idle_stall"}, {31'd0, Stall_o}, 32'd0);
        tick();
    endtask

    initial begin
        int hi;
        rst_ni = 1'b0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; MemType_i = 2'b00; MemSign_i = 1'b0;
        Addr_i = '0; WriteData_i = '0;
        MemGnt_i = 1'b0; MemRValid_i = 1'b0; MemRData_i = '0;

        //          rd wr typ   sgn addr         wdata         rdata         g  r  mis be       maddr         mwdata        exp_rd
        vecs[0]  = '{1, 0, 2'b01, 0, 32'h1003, 32'h0,        32'h80000000, 0, 0, 0, 4'b1000, 32'h1000, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{0, 1, 2'b10, 0, 32'h2002, 32'h1234ABCD, 32'h0,        0, 0, 0, 4'b1100, 32'h2000, 32'hABCDABCD, 32'hFFFFFF80};
        vecs[2]  = '{1, 0, 2'b10, 1, 32'h0002, 32'h0,        32'hF00D1234, 3, 0, 0, 4'b1100, 32'h0000, 32'h0,        32'h0000F00D};
        vecs[3]  = '{1, 0, 2'b00, 0, 32'h0006, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,    32'h0,        32'h0000F00D};
        vecs[4]  = '{0, 1, 2'b01, 0, 32'h3001, 32'h000000A5, 32'h0,        1, 0, 0, 4'b0010, 32'h3000, 32'hA5A5A5A5, 32'h0000F00D};
        vecs[5]  = '{1, 0, 2'b00, 0, 32'h0040, 32'h0,        32'hDEADBEEF, 0, 2, 0, 4'b1111, 32'h0040, 32'h0,        32'hDEADBEEF};
        vecs[6]  = '{1, 0, 2'b01, 1, 32'h0041, 32'h0,        32'h1234F6FF, 0, 0, 0, 4'b0010, 32'h0040, 32'h0,        32'h000000F6};
        vecs[7]  = '{1, 0, 2'b10, 0, 32'h0042, 32'h0,        32'h80017FFF, 0, 1, 0, 4'b1100, 32'h0040, 32'h0,        32'hFFFF8001};
        vecs[8]  = '{0, 1, 2'b10, 0, 32'h0045, 32'h5555,     32'h0,        0, 0, 1, 4'b0000, 32'h0,    32'h0,        32'hFFFF8001};
        vecs[9]  = '{1, 1, 2'b00, 0, 32'h0080, 32'hCAFEF00D, 32'h0,        0, 0, 0, 4'b1111, 32'h0080, 32'hCAFEF00D, 32'hFFFF8001};
        vecs[10] = '{1, 0, 2'b11, 0, 32'h0084, 32'h0,        32'h01020304, 0, 0, 0, 4'b1111, 32'h0084, 32'h0,        32'h01020304};
        vecs[11] = '{1, 0, 2'b11, 0, 32'h0086, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,    32'h0,        32'h01020304};
        vecs[12] = '{1, 0, 2'b10, 0, 32'h0050, 32'h0,        32'h00007FFF, 0, 0, 0, 4'b0011, 32'h0050, 32'h0,        32'h00007FFF};

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_rd", ReadData_o, 32'h0);
        chk("rst_flags", {26'd0, Stall_o, Done_o, Misalign_o, BusErr_o, MemReq_o, MemWe_o}, 32'h0);
        chk("rst_addr", MemAddr_o, 32'h0);
        chk("rst_be", {28'd0, MemBe_o}, 32'h0);
        chk("rst_wdata", MemWData_o, 32'h0);
        #1 rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // No grant at all: bus error after 64 cycles of request
        start_load(32'h100);
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_i);
            if (MemReq_o && !Done_o) hi++;
            tick();
        end
        chk("tmo_req_cycles", hi, 64);
        @(negedge clk_i);
        chk("tmo_done", {31'd0, Done_o}, 32'd1);
        chk("tmo_berr", {31'd0, BusErr_o}, 32'd1);
        chk("tmo_req", {31'd0, MemReq_o}, 32'd0);
        chk("tmo_mis", {31'd0, Misalign_o}, 32'd0);
        chk("tmo_rd", ReadData_o, 32'h00007FFF);
        finish_idle("tmo");

        // Grant at once but no read data: timeout counted across REQ and WAIT
        start_load(32'h104);
        @(negedge clk_i);
        MemGnt_i = 1'b1;
        tick();
        MemGnt_i = 1'b0;
        hi = 0;
        for (int k = 0; k < 63; k++) begin
            @(negedge clk_i);
            if (Stall_o && !MemReq_o && !Done_o) hi++;
            tick();
        end
        chk("tmow_wait_cycles", hi, 63);
        @(negedge clk_i);
        chk("tmow_done", {31'd0, Done_o}, 32'd1);
        chk("tmow_berr", {31'd0, BusErr_o}, 32'd1);
        chk("tmow_rd", ReadData_o, 32'h00007FFF);
        finish_idle("tmow");

        // Grant on the last allowed cycle wins over the timeout
        start_load(32'h108);
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_i);
            if (MemReq_o) hi++;
            if (k == 63) MemGnt_i = 1'b1;
            tick();
            MemGnt_i = 1'b0;
        end
        chk("g63_req_cycles", hi, 64);
        @(negedge clk_i);
        chk("g63_wait_stall", {31'd0, Stall_o}, 32'd1);
        chk("g63_wait_done", {31'd0, Done_o}, 32'd0);
        MemRValid_i = 1'b1;
        MemRData_i  = 32'h5A5A1234;
        tick();
        MemRValid_i = 1'b0;
        @(negedge clk_i);
        chk("g63_done", {31'd0, Done_o}, 32'd1);
        chk("g63_berr", {31'd0, BusErr_o}, 32'd0);
        chk("g63_rd", ReadData_o, 32'h5A5A1234);
        finish_idle("g63");

        // Reset in WAIT, then stray handshake strobes after release
        start_load(32'h200);
        @(negedge clk_i);
        MemGnt_i = 1'b1;
        tick();
        MemGnt_i = 1'b0;
        @(negedge clk_i);
        chk("rw_wait_stall", {31'd0, Stall_o}, 32'd1);
        #2;
        MemRead_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rw_rd", ReadData_o, 32'h0);
        chk("rw_flags", {26'd0, Stall_o, Done_o, Misalign_o, BusErr_o, MemReq_o, MemWe_o}, 32'h0);
        chk("rw_bus", MemAddr_o | MemWData_o | {28'd0, MemBe_o}, 32'h0);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        MemRValid_i = 1'b1;
        MemGnt_i    = 1'b1;
        MemRData_i  = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk_i);
            chk($sformatf("rw_stray_rd_%0d", k), ReadData_o, 32'h0);
            chk($sformatf("rw_stray_flags_%0d", k), {28'd0, Stall_o, Done_o, MemReq_o, BusErr_o}, 32'h0);
        end
        MemRValid_i = 1'b0;
        MemGnt_i    = 1'b0;
        tick();

        // Normal operation resumes after reset
        run_vec(0, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
